bk_adder_pipe: RTL
==================

# bk_adder_pipe

Parametrised, pipelined Brent-Kung adder/subtractor with valid/ready handshaking. It is the successor to the fixed 32-bit combinational carry adder: it generalises width, selects add or subtract per transaction, reports carry-out and signed overflow, and registers the datapath in 1–3 stages. Full backpressure lets it sit directly in streaming arithmetic datapaths.

## Interface
- WIDTH, 32: operand width; power of two, 8..64.
- PIPE, 3: number of register stages (1, 2 or 3); equals the latency in cycles.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1 = compute a − b (a + ~b + 1).
- sat  in  1  saturate on signed overflow; ignored unless the macro is defined.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result bits [WIDTH-1:0].
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- Stage 1 (operand conditioning): b_eff = sub ? ~b : b; c0 = sub ? 1 : cin; P = a ^ b_eff; G = a & b_eff.
- Stage 2 (carry network): Brent-Kung prefix tree with 2·log2(WIDTH)−1 levels producing carries C[0..WIDTH].
- Stage 3 (sum): sum = P ^ C[WIDTH-1:0]; cout = C[WIDTH]; ovf = C[WIDTH-1] ^ C[WIDTH].
- Register placement:
  - PIPE=3: registers after stages 1, 2 and 3.
  - PIPE=2: registers after stage 2 and stage 3.
  - PIPE=1: output register only.
- Each pipeline register has a valid bit. Stage k loads when its own valid is 0 or stage k+1 can accept. The output stage can accept when out_valid=0 or out_ready=1.
- in_ready = stage-1 register can accept. Bubbles collapse. There is no combinational path from in_valid to out_valid.
- A beat transfers on in_valid & in_ready; a result leaves on out_valid & out_ready.
- While out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
- Data registers load only on a transfer.
- No reordering. No beats are dropped or duplicated.

## Timing
- Reset: all valid bits go to 0, out_valid=0, sum=0, cout=0, ovf=0.
- in_ready=1 in the first cycle after rst deasserts.
- Reset mid-stream: every in-flight beat is discarded. No partial result is emitted.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+PIPE−1, i.e. on the PIPE-th edge counting the accept edge. This holds when the pipeline is not stalled.
- Throughput: one beat per cycle while out_ready=1.
- Accept and emit in the same cycle on a full pipeline: allowed, because in_ready follows downstream readiness combinationally through the stages.
- Wrap-around: modular arithmetic. For example, 0xFFFF_FFFF + 1 gives sum=0, cout=1, ovf=0.

## Configuration
- BK_ADDER_SAT_EN defined: a beat with sat=1 and ovf=1 outputs the signed extreme instead of the wrapped sum.
  - Clamp value: 0x7F…F if a[MSB]=0, else 0x80…0.
  - ovf and cout still report the raw result.
  - The clamp is applied in stage 3, so latency is unchanged.
- BK_ADDER_SAT_EN undefined: the sat port exists but is ignored. sum always wraps, and no clamp logic is generated.

## Structure
- Package bk_adder_pkg contains:
  - function clog2-based bk_levels(width), returning 2·log2(width)−1;
  - localparams PIPE_MIN=1 and PIPE_MAX=3;
  - typedef stage-1 payload struct {P, G, c0, a_msb, sat} parametrised via WIDTH_MAX=64 (unused bits tied 0).
- One sub-module, bk_prefix_tree:
  - purely combinational;
  - parameter WIDTH; inputs P, G, c0; output C[WIDTH:0];
  - up-sweep and down-sweep as generate loops.
- The pipeline and handshake logic stay in bk_adder_pipe.

## Test plan
- Reset, then apply a=0x0000_0005, b=0x0000_0003, sub=0, cin=1 with PIPE=3 and out_ready=1 → exactly 3 cycles later sum=0x9, cout=0, ovf=0.
- Subtract a=3, b=5, sub=1 → sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0. Then a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, ovf=1.
- Stream 100 random beats with out_ready toggled pseudo-randomly (50%) for each PIPE in 1, 2, 3 → results in order and match the golden model, with outputs stable while stalled.
- Hold out_ready=0 with in_valid=1 → in_ready falls after PIPE beats are accepted. Releasing out_ready drains the beats at one per cycle.
- Assert rst with 3 beats in flight → out_valid=0 the next cycle. Those beats never appear, and the next accepted beat has the nominal latency.
- With BK_ADDER_SAT_EN: a=0x7FFF_FFFF, b=1, sat=1 → sum=0x7FFF_FFFF, ovf=1. The same beat without the macro → sum=0x8000_0000.

Source files
------------

// File: rtl/bk_adder_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder/subtractor.
// Payload structs are sized for the widest supported operand; unused upper bits stay 0.
// Stateless package: no latency or backpressure of its own.
package bk_adder_pkg;

    localparam int WIDTH_MAX = 64;
    localparam int PIPE_MIN  = 1;
    localparam int PIPE_MAX  = 3;

    typedef struct packed {
        logic [WIDTH_MAX-1:0] p;
        logic [WIDTH_MAX-1:0] g;
        logic                 c0;
        logic                 a_msb;
        logic                 sat;
    } s1_t;

    typedef struct packed {
        logic [WIDTH_MAX-1:0] p;
        logic [WIDTH_MAX:0]   c;
        logic                 a_msb;
        logic                 sat;
    } s2_t;

    function automatic int bk_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Brent-Kung carry prefix network: carries C[0..WIDTH] from propagate/generate and carry-in.
// Latency: purely combinational, 2*log2(WIDTH)-1 operator levels.
// Backpressure: none, no state.
module bk_prefix_tree
    import bk_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             c0,
    output logic [WIDTH:0]   c
);

    localparam int NLEV = bk_levels(WIDTH);
    localparam int LOG  = (NLEV + 1) / 2;

    logic [NLEV:0][WIDTH-1:0] gl;
    logic [NLEV:0][WIDTH-1:0] pl;
    logic                     unused_p;

    // Carry-in folded into bit 0 so every group generate is a true carry.
    assign gl[0] = {g[WIDTH-1:1], g[0] | (p[0] & c0)};
    assign pl[0] = p;

    for (genvar lv = 1; lv <= NLEV; lv++) begin : g_lvl
        localparam bit UP   = (lv <= LOG);
        localparam int DIST = UP ? (1 << (lv - 1)) : (1 << (2 * LOG - 1 - lv));
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam bit OP = UP ? (((i + 1) % (2 * DIST)) == 0)
                                   : ((((i + 1) % (2 * DIST)) == DIST) && (i >= 2 * DIST));
            if (OP) begin : g_op
                assign gl[lv][i] = gl[lv-1][i] | (pl[lv-1][i] & gl[lv-1][i-DIST]);
                assign pl[lv][i] = pl[lv-1][i] & pl[lv-1][i-DIST];
            end else begin : g_pass
                assign gl[lv][i] = gl[lv-1][i];
                assign pl[lv][i] = pl[lv-1][i];
            end
        end
    end

    assign c        = {gl[NLEV], c0};
    assign unused_p = ^pl;

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung add/sub with carry-out and signed overflow; BK_ADDER_SAT_EN adds saturation.
// Latency: PIPE cycles (1..3), one beat per cycle when unstalled.
// Backpressure: per-stage valid, each stage loads when empty or next accepts; in_ready follows out_ready combinationally.
module bk_adder_pipe
    import bk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;
    logic             s1_vld, s2_vld;
    logic             acc1, acc2, acc3;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d;
    logic             unused_bits;

    assign b_eff = sub ? ~b : b;

    always_comb begin
        s1_d                = '0;
        s1_d.p[WIDTH-1:0]   = a ^ b_eff;
        s1_d.g[WIDTH-1:0]   = a & b_eff;
        s1_d.c0             = sub | cin;
        s1_d.a_msb          = a[WIDTH-1];
`ifdef BK_ADDER_SAT_EN
        s1_d.sat            = sat;
`else
        s1_d.sat            = 1'b0;
`endif
    end

    if (PIPE == PIPE_MAX) begin : g_s1_reg
        logic v1;
        s1_t  q1;
        always_ff @(posedge clk) begin
            if (rst) begin
                v1 <= 1'b0;
                q1 <= '0;
            end else if (acc1) begin
                v1 <= in_valid;
                if (in_valid) q1 <= s1_d;
            end
        end
        assign acc1   = !v1 || acc2;
        assign s1_q   = q1;
        assign s1_vld = v1;
    end else begin : g_s1_comb
        assign acc1   = acc2;
        assign s1_q   = s1_d;
        assign s1_vld = in_valid;
    end

    bk_prefix_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .p  (s1_q.p[WIDTH-1:0]),
        .g  (s1_q.g[WIDTH-1:0]),
        .c0 (s1_q.c0),
        .c  (carry)
    );

    always_comb begin
        s2_d              = '0;
        s2_d.p[WIDTH-1:0] = s1_q.p[WIDTH-1:0];
        s2_d.c[WIDTH:0]   = carry;
        s2_d.a_msb        = s1_q.a_msb;
        s2_d.sat          = s1_q.sat;
    end

    if (PIPE > PIPE_MIN) begin : g_s2_reg
        logic v2;
        s2_t  q2;
        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= 1'b0;
                q2 <= '0;
            end else if (acc2) begin
                v2 <= s1_vld;
                if (s1_vld) q2 <= s2_d;
            end
        end
        assign acc2   = !v2 || acc3;
        assign s2_q   = q2;
        assign s2_vld = v2;
    end else begin : g_s2_comb
        assign acc2   = acc3;
        assign s2_q   = s2_d;
        assign s2_vld = s1_vld;
    end

    always_comb begin
        cout_d = s2_q.c[WIDTH];
        ovf_d  = s2_q.c[WIDTH-1] ^ s2_q.c[WIDTH];
        sum_d  = s2_q.p[WIDTH-1:0] ^ s2_q.c[WIDTH-1:0];
`ifdef BK_ADDER_SAT_EN
        // Clamp toward the sign of a; cout/ovf keep reporting the raw result.
        if (s2_q.sat && ovf_d)
            sum_d = s2_q.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    assign acc3 = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (acc3) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                sum  <= sum_d;
                cout <= cout_d;
                ovf  <= ovf_d;
            end
        end
    end

    assign in_ready    = acc1;
    assign unused_bits = ^{s1_q, s2_q, sat};

endmodule
